// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_pkg.sv
// Shared definitions for the TPL DAC start-up sequencer: state encoding and
// small decode helpers used by the controller.
package ad_ip_jesd204_tpl_dac_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_RUN   = 2'd3
    } sync_state_t;

    localparam int DEFAULT_DELAY_WIDTH = 16;
    localparam int DEFAULT_COUNT_WIDTH = 8;

    function automatic logic state_is_busy(input sync_state_t s);
        return (s == ST_ARMED) || (s == ST_DELAY);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sync_edge.sv
// Rising-edge detector for a clk-synchronous sync level. History resets to 1 so
// a level that is already high when reset releases is not reported as an edge.
module ad_ip_jesd204_tpl_dac_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Link-clock sequencer deciding when DAC data is released onto the JESD link:
// free start, software sync or armed external sync, then a gated start delay.
module ad_ip_jesd204_tpl_dac_sync_ctrl
    import ad_ip_jesd204_tpl_dac_sync_ctrl_pkg::*;
#(
    parameter int DELAY_WIDTH = DEFAULT_DELAY_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sync_req,
    input  logic                   arm_req,
    input  logic                   disarm_req,
    input  logic                   ext_sync,
    input  logic                   link_ready,
    input  logic [DELAY_WIDTH-1:0] start_delay,
    output logic                   data_en,
    output logic                   dds_sync,
    output logic                   armed,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] sync_count
);

    sync_state_t            state_q;
    sync_state_t            state_d;
    logic [DELAY_WIDTH-1:0] cnt_q;
    logic [DELAY_WIDTH-1:0] cnt_d;
    logic                   ext_edge;

    ad_ip_jesd204_tpl_dac_sync_edge u_ext_edge (
        .clk    (clk),
        .resetn (resetn),
        .level  (ext_sync),
        .rise   (ext_edge)
    );

    // Ignored requests fall through to the next lower-priority request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_req) begin
                    state_d = ST_ARMED;
                end else if (sync_req) begin
                    state_d = ST_DELAY;
                    cnt_d   = start_delay;
                end
            end
            ST_ARMED: begin
                if (disarm_req) begin
                    state_d = ST_IDLE;
                end else if (sync_req || ext_edge) begin
                    state_d = ST_DELAY;
                    cnt_d   = start_delay;
                end
            end
            ST_DELAY: begin
                if (disarm_req) begin
                    state_d = ST_IDLE;
                end else if (arm_req) begin
                    state_d = ST_ARMED;
                end else if (sync_req) begin
                    cnt_d = start_delay;
                end else if (link_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - DELAY_WIDTH'(1);
                    end
                end
            end
            ST_RUN: begin
                if (arm_req) begin
                    state_d = ST_ARMED;
                end else if (sync_req) begin
                    state_d = ST_DELAY;
                    cnt_d   = start_delay;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_en    <= 1'b0;
            dds_sync   <= 1'b0;
            armed      <= 1'b0;
            busy       <= 1'b0;
            sync_count <= '0;
        end else begin
            data_en  <= (state_d == ST_RUN);
            dds_sync <= (state_d == ST_RUN) && (state_q != ST_RUN);
            armed    <= (state_d == ST_ARMED);
            busy     <= state_is_busy(state_d);
            if ((state_q == ST_DELAY) && (state_d == ST_RUN) && (sync_count != '1)) begin
                sync_count <= sync_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_sync_ctrl: directed scenarios
// followed by random traffic, all checked against a flag-based reference model.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

    logic        clk;
    logic        resetn;
    logic        sync_req;
    logic        arm_req;
    logic        disarm_req;
    logic        ext_sync;
    logic        link_ready;
    logic [15:0] start_delay;
    logic        data_en;
    logic        dds_sync;
    logic        armed;
    logic        busy;
    logic [7:0]  sync_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: waiting-for-edge flag, running flag, remaining delay
    // cycles (-1 when no delay is pending) and a plain entry counter.
    bit m_armed;
    bit m_run;
    bit m_dds;
    bit m_prev;
    int m_rem;
    int m_count;

    ad_ip_jesd204_tpl_dac_sync_ctrl #(
        .DELAY_WIDTH (16),
        .COUNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sync_req    (sync_req),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .ext_sync    (ext_sync),
        .link_ready  (link_ready),
        .start_delay (start_delay),
        .data_en     (data_en),
        .dds_sync    (dds_sync),
        .armed       (armed),
        .busy        (busy),
        .sync_count  (sync_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_run   = 1'b0;
        m_dds   = 1'b0;
        m_prev  = 1'b1;
        m_rem   = -1;
        m_count = 0;
    endtask

    task automatic model_step();
        bit edge_s;
        bit delaying;
        edge_s   = ext_sync && !m_prev;
        m_prev   = ext_sync;
        m_dds    = 1'b0;
        delaying = (m_rem >= 0);
        if (m_armed) begin
            if (disarm_req) begin
                m_armed = 1'b0;
            end else if (sync_req || edge_s) begin
                m_armed = 1'b0;
                m_rem   = int'(start_delay);
            end
        end else if (delaying) begin
            if (disarm_req) begin
                m_rem = -1;
            end else if (arm_req) begin
                m_rem   = -1;
                m_armed = 1'b1;
            end else if (sync_req) begin
                m_rem = int'(start_delay);
            end else if (link_ready) begin
                if (m_rem == 0) begin
                    m_rem   = -1;
                    m_run   = 1'b1;
                    m_dds   = 1'b1;
                    m_count = m_count + 1;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end else if (m_run) begin
            if (arm_req) begin
                m_run   = 1'b0;
                m_armed = 1'b1;
            end else if (sync_req) begin
                m_run = 1'b0;
                m_rem = int'(start_delay);
            end
        end else begin
            if (arm_req) begin
                m_armed = 1'b1;
            end else if (sync_req) begin
                m_rem = int'(start_delay);
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data_en"}, 32'(data_en), 32'(m_run));
        check({tag, ".dds_sync"}, 32'(dds_sync), 32'(m_dds));
        check({tag, ".armed"}, 32'(armed), 32'(m_armed));
        check({tag, ".busy"}, 32'(busy), 32'(m_armed || (m_rem >= 0)));
        check({tag, ".sync_count"}, 32'(sync_count), (m_count > 255) ? 32'd255 : 32'(m_count));
    endtask

    // One clock: inputs were set at the preceding negedge; outputs are
    // compared at the following negedge, then one-shot requests clear.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
        sync_req   = 1'b0;
        arm_req    = 1'b0;
        disarm_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data_en"}, 32'(data_en), 32'd0);
        check({tag, ".dds_sync"}, 32'(dds_sync), 32'd0);
        check({tag, ".armed"}, 32'(armed), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".sync_count"}, 32'(sync_count), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        sync_req    = 1'b0;
        arm_req     = 1'b0;
        disarm_req  = 1'b0;
        ext_sync    = 1'b1;
        link_ready  = 1'b1;
        start_delay = 16'd0;
        model_reset();

        // Reset held with ext_sync high, then released: must stay idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        repeat (8) tick("idle_ext_high");
        check("idle_ext_high.busy_final", 32'(busy), 32'd0);

        // Software sync with start_delay=3: four DELAY cycles, then RUN.
        start_delay = 16'd3;
        sync_req    = 1'b1;
        tick("sync_d3");
        check("sync_d3.delay_entry", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick("sync_d3");
            check("sync_d3.still_delay", 32'(data_en), 32'd0);
        end
        tick("sync_d3");
        check("sync_d3.dds_first", 32'(dds_sync), 32'd1);
        check("sync_d3.data_en_first", 32'(data_en), 32'd1);
        tick("sync_d3");
        check("sync_d3.dds_single", 32'(dds_sync), 32'd0);
        check("sync_d3.count", 32'(sync_count), 32'd1);

        // Arm, then an external edge with start_delay=0.
        start_delay = 16'd0;
        ext_sync    = 1'b0;
        arm_req     = 1'b1;
        tick("arm_ext");
        check("arm_ext.data_en_drop", 32'(data_en), 32'd0);
        repeat (3) tick("arm_ext");
        check("arm_ext.armed_before", 32'(armed), 32'd1);
        ext_sync = 1'b1;
        tick("arm_ext");
        check("arm_ext.armed_after", 32'(armed), 32'd0);
        tick("arm_ext");
        check("arm_ext.dds", 32'(dds_sync), 32'd1);
        check("arm_ext.count", 32'(sync_count), 32'd2);

        // start_delay=5 with link_ready dropped for 4 cycles: RUN 4 cycles late.
        start_delay = 16'd5;
        sync_req    = 1'b1;
        tick("gap");
        for (int k = 1; k <= 9; k++) begin
            link_ready = (k >= 3 && k <= 6) ? 1'b0 : 1'b1;
            if (k == 4) start_delay = 16'd0;
            tick("gap");
            check("gap.no_run_yet", 32'(data_en), 32'd0);
        end
        link_ready = 1'b1;
        tick("gap");
        check("gap.run", 32'(dds_sync), 32'd1);

        // Disarm beats an external edge in the same cycle.
        ext_sync = 1'b0;
        arm_req  = 1'b1;
        tick("disarm_prio");
        tick("disarm_prio");
        ext_sync   = 1'b1;
        disarm_req = 1'b1;
        tick("disarm_prio");
        check("disarm_prio.busy", 32'(busy), 32'd0);
        tick("disarm_prio");
        check("disarm_prio.still_idle", 32'(busy), 32'd0);

        // arm_req while running drops data_en at once.
        start_delay = 16'd0;
        sync_req    = 1'b1;
        repeat (3) tick("arm_in_run");
        check("arm_in_run.running", 32'(data_en), 32'd1);
        arm_req = 1'b1;
        tick("arm_in_run");
        check("arm_in_run.data_en", 32'(data_en), 32'd0);
        check("arm_in_run.armed", 32'(armed), 32'd1);

        // Async reset in the middle of a delay.
        start_delay = 16'd5;
        sync_req    = 1'b1;
        repeat (3) tick("reset_mid_delay");
        apply_reset("reset_mid_delay");
        repeat (2) tick("post_reset");

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            sync_req    = ($urandom_range(0, 19) == 0);
            arm_req     = ($urandom_range(0, 29) == 0);
            disarm_req  = ($urandom_range(0, 29) == 0);
            link_ready  = ($urandom_range(0, 5) != 0);
            start_delay = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) ext_sync = ~ext_sync;
            tick("random");
        end

        // 260 completed syncs: counter saturates at 255.
        link_ready  = 1'b1;
        ext_sync    = 1'b0;
        start_delay = 16'd0;
        for (int n = 0; n < 260; n++) begin
            sync_req = 1'b1;
            repeat (3) tick("saturate");
        end
        check("saturate.count", 32'(sync_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
